// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension execute unit: one-cycle multiply, radix-2 restoring divide.
// Handshake: start accepted in IDLE, busy while working, one-cycle done pulse with held result.
module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [4:0]      alu_sel,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CW       = $clog2(XLEN);
    localparam logic [4:0]  ALU_MUL  = 5'd16;
    localparam logic [4:0]  ALU_REMU = 5'd23;
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t          state;
    logic [2:0]      op_q;
    logic [XLEN-1:0] a_q, b_q, quot_q, rem_q;
    logic [CW-1:0]   cnt;

    // Request decode on the raw inputs
    logic            is_m, in_sdiv, in_dz, in_ovf;
    logic [2:0]      in_f;
    logic [XLEN-1:0] a_mag_in;

    always_comb begin
        is_m     = (alu_sel >= ALU_MUL) && (alu_sel <= ALU_REMU);
        in_f     = 3'(alu_sel - ALU_MUL);
        in_sdiv  = ~in_f[0];
        in_dz    = (op_b == '0);
        in_ovf   = in_sdiv && (op_a == SMIN) && (op_b == '1);
        a_mag_in = (in_sdiv && op_a[XLEN-1]) ? -op_a : op_a;
    end

    // Full-width product with per-op operand sign extension
    logic              a_s, b_s;
    logic [2*XLEN-1:0] a_ext, b_ext, prod;

    always_comb begin
        a_s   = (op_q[1:0] == 2'b01) || (op_q[1:0] == 2'b10);
        b_s   = (op_q[1:0] == 2'b01);
        a_ext = {{XLEN{a_s & a_q[XLEN-1]}}, a_q};
        b_ext = {{XLEN{b_s & b_q[XLEN-1]}}, b_q};
        prod  = a_ext * b_ext;
    end

    // One restoring-division step plus final sign/special-case correction
    logic            sgn, neg_q, neg_r, dz, ovf;
    logic [XLEN-1:0] b_mag, q_fin, r_fin, fix_res;
    logic [XLEN:0]   shifted, diff;

    always_comb begin
        sgn     = ~op_q[0];
        b_mag   = (sgn && b_q[XLEN-1]) ? -b_q : b_q;
        shifted = {rem_q, quot_q[XLEN-1]};
        diff    = shifted - {1'b0, b_mag};
        neg_q   = sgn & (a_q[XLEN-1] ^ b_q[XLEN-1]);
        neg_r   = sgn & a_q[XLEN-1];
        dz      = (b_q == '0);
        ovf     = sgn && (a_q == SMIN) && (b_q == '1);
        q_fin   = neg_q ? -quot_q : quot_q;
        r_fin   = neg_r ? -rem_q : rem_q;
        if (dz) begin
            q_fin = '1;
            r_fin = a_q;
        end else if (ovf) begin
            q_fin = a_q;
            r_fin = '0;
        end
        fix_res = op_q[1] ? r_fin : q_fin;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            cnt    <= '0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            quot_q <= '0;
            rem_q  <= '0;
        end else if (state != S_IDLE && flush) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start && !flush && is_m) begin
                        a_q    <= op_a;
                        b_q    <= op_b;
                        op_q   <= in_f;
                        cnt    <= '0;
                        quot_q <= a_mag_in;
                        rem_q  <= '0;
                        busy   <= 1'b1;
                        if (!in_f[2])              state <= S_MUL;
                        else if (in_dz || in_ovf)  state <= S_FIX;
                        else                       state <= S_DIV;
                    end
                end
                S_MUL: begin
                    result <= (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
                    done   <= 1'b1;
                    state  <= S_DONE;
                end
                S_DIV: begin
                    if (!diff[XLEN]) begin
                        rem_q  <= diff[XLEN-1:0];
                        quot_q <= {quot_q[XLEN-2:0], 1'b1};
                    end else begin
                        rem_q  <= shifted[XLEN-1:0];
                        quot_q <= {quot_q[XLEN-2:0], 1'b0};
                    end
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(XLEN - 1)) state <= S_FIX;
                end
                S_FIX: begin
                    result <= fix_res;
                    done   <= 1'b1;
                    state  <= S_DONE;
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed + randomized scoreboard bench for muldiv_unit (XLEN=32).
module tb_muldiv_unit;

    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_MUL    = 5'd16;
    localparam logic [4:0] ALU_MULH   = 5'd17;
    localparam logic [4:0] ALU_MULHSU = 5'd18;
    localparam logic [4:0] ALU_MULHU  = 5'd19;
    localparam logic [4:0] ALU_DIV    = 5'd20;
    localparam logic [4:0] ALU_DIVU   = 5'd21;
    localparam logic [4:0] ALU_REM    = 5'd22;
    localparam logic [4:0] ALU_REMU   = 5'd23;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [4:0]  alu_sel;
    logic [31:0] op_a, op_b;
    logic        busy, done;
    logic [31:0] result;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] sb_q[$];
    logic [31:0] last_res;

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .flush(flush), .alu_sel(alu_sel),
        .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model from native 64-bit arithmetic and the RISC-V special cases
    function automatic logic [31:0] model(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        p  = '0;
        case (sel)
            ALU_MUL:    begin p = sa * sb;           return p[31:0];  end
            ALU_MULH:   begin p = sa * sb;           return p[63:32]; end
            ALU_MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
            ALU_MULHU:  begin p = ua * ub;           return p[63:32]; end
            ALU_DIV:  if (b == 0) return 32'hFFFF_FFFF;
                      else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                      else return 32'(sa / sb);
            ALU_DIVU: if (b == 0) return 32'hFFFF_FFFF; else return 32'(ua / ub);
            ALU_REM:  if (b == 0) return a;
                      else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                      else return 32'(sa % sb);
            ALU_REMU: if (b == 0) return a; else return 32'(ua % ub);
            default:  return 32'h0;
        endcase
    endfunction

    function automatic int exp_lat(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
        if (sel < ALU_DIV) return 2;
        if (b == 0) return 2;
        if ((sel == ALU_DIV || sel == ALU_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return 34;
    endfunction

    // Called right after a negedge; poke>0 re-asserts start (MUL 2*3) at that cycle while busy
    task automatic run_op(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input int poke);
        logic [31:0] got;
        bit          seen;
        alu_sel = sel; op_a = a; op_b = b; start = 1'b1;
        sb_q.push_back(exp);
        seen = 1'b0;
        for (int k = 1; k <= 200 && !seen; k++) begin
            @(negedge clk);
            start = (k == poke);
            if (k == poke) begin
                alu_sel = ALU_MUL; op_a = 32'd2; op_b = 32'd3;
            end
            if (done) begin
                seen = 1'b1;
                check("latency", 32'(k), 32'(lat));
                got = sb_q.pop_front();
                check("result", result, got);
                last_res = got;
            end else begin
                check("busy_while_running", 32'(busy), 32'd1);
            end
        end
        if (!seen) begin
            check("done_timeout", 32'd0, 32'd1);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
        end
        start = 1'b0;
        @(negedge clk);
        check("done_single_pulse", 32'(done), 32'd0);
        check("idle_after_done", 32'(busy), 32'd0);
        check("result_hold", result, last_res);
    endtask

    initial begin
        logic [4:0]  rs;
        logic [31:0] ra, rb;
        rst = 1'b1; start = 1'b0; flush = 1'b0;
        alu_sel = ALU_ADD; op_a = '0; op_b = '0; last_res = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", result, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(ALU_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 2, 0);
        run_op(ALU_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 2, 0);
        run_op(ALU_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 2, 0);
        run_op(ALU_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 0);

        run_op(ALU_DIV,  32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 34, 0);
        run_op(ALU_REM,  32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 34, 0);

        run_op(ALU_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 2, 0);
        run_op(ALU_REMU, 32'd5,         32'd0,         32'd5,         2, 0);
        run_op(ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, 0);
        run_op(ALU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         2, 0);
        run_op(ALU_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0B00_EA4E, 2, 0);

        // Flush a divide at cycle 10: no done, result keeps the old value
        alu_sel = ALU_DIVU; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
            check("flush_pre_done", 32'(done), 32'd0);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_done", 32'(done), 32'd0);
        check("flush_result", result, last_res);
        run_op(ALU_DIVU, 32'd100, 32'd7, 32'd14, 34, 0);

        // Start while busy is ignored
        run_op(ALU_DIVU, 32'd100, 32'd7, 32'd14, 34, 5);

        // Non-M select is ignored
        alu_sel = ALU_ADD; op_a = 32'd1; op_b = 32'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("nonm_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("nonm_done", 32'(done), 32'd0);
        check("nonm_result", result, last_res);

        // Flush together with start in IDLE: not accepted
        alu_sel = ALU_MUL; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush_start_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("flush_start_done", 32'(done), 32'd0);

        // Reset in the middle of a divide
        alu_sel = ALU_DIV; op_a = 32'd1000; op_b = 32'd3; start = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_result", result, 32'd0);
        last_res = 32'd0;
        @(negedge clk);
        check("midrst_no_done", 32'(done), 32'd0);

        for (int i = 0; i < 12; i++) begin
            rs = 5'(ALU_MUL + 5'($urandom_range(0, 7)));
            ra = $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if (i == 7) begin
                rs = ALU_REM; ra = 32'h8000_0000; rb = 32'hFFFF_FFFF;
            end
            run_op(rs, ra, rb, model(rs, ra, rb), exp_lat(rs, ra, rb), 0);
        end

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
